transaction_sequencer: RTL and testbench
========================================

Name: transaction_sequencer

Overview:
Parametrised successor to the fixed four-step transaction controller. It sequences NUM_STEPS (travel, step) phase pairs for one transaction, then reports success or failure. It adds step-failure reporting, external abort, a per-phase watchdog timeout and a saturating count of completed transactions. It sits between the transaction front end and the verify/sign/mine datapath, which it drives through the step/travel index buses.

Parameters:
NUM_STEPS, 4, number of travel+step phase pairs per transaction (>=1).
IDX_W, 3, width of step/travel/fail_code buses; must satisfy 2^IDX_W > NUM_STEPS.
TIMEOUT_CYCLES, 0, max cycles spent in one TRAVEL or STEP phase; 0 disables the watchdog.
CNT_W, 8, width of the completed-transaction counter.

Ports:
clock  input  1  system clock, all state updates on posedge.
resetn  input  1  synchronous active-low reset, sampled on posedge clock.
start_transaction  input  1  request a new transaction; honoured only in IDLE.
done_travel  input  1  current travel phase complete.
done_step  input  1  current step computation complete.
step_fail  input  1  current step finished unsuccessfully; only meaningful in STEP.
abort  input  1  cancel the transaction in progress.
step  output  IDX_W  1-based index of the active phase pair during TRAVEL and STEP; 0 otherwise.
travel  output  IDX_W  equals step during TRAVEL; 0 otherwise.
busy  output  1  high in TRAVEL and STEP.
finished_transaction  output  1  one-cycle pulse on success.
failed_transaction  output  1  one-cycle pulse on failure.
fail_code  output  IDX_W  index of the phase pair that failed; held until the next start is accepted.
timeout  output  1  set with failed_transaction when the failure cause is the watchdog; held like fail_code.
done_count  output  CNT_W  number of successful transactions, saturating.

Behaviour:
- States: IDLE, TRAVEL, STEP, DONE, FAIL. Moore outputs decode from registered state plus registered idx (1..NUM_STEPS).
- Reset, synchronous, when resetn=0 at posedge:
  - state=IDLE, idx=0, watchdog=0, fail_code=0, timeout=0, done_count=0.
  - All outputs therefore read 0 the following cycle.
  - Reset mid-transaction abandons it; no finished or failed pulse is generated.
- IDLE:
  - start_transaction=1 at edge k → TRAVEL with idx=1. From cycle k+1: travel=1, step=1, busy=1.
  - The same edge clears fail_code and timeout.
  - start_transaction outside IDLE is ignored (no queuing).
- TRAVEL, priority abort > done_travel > timeout:
  - abort → FAIL.
  - done_travel → STEP with the same idx.
  - Watchdog expiry → FAIL with timeout=1.
- STEP, priority abort > step_fail > done_step > timeout:
  - abort or step_fail → FAIL.
  - done_step with idx<NUM_STEPS → TRAVEL with idx+1.
  - done_step with idx==NUM_STEPS → DONE.
  - Watchdog expiry → FAIL with timeout=1.
- Simultaneous done and timeout on the same edge: done wins. Simultaneous step_fail and done_step: failure wins.
- DONE lasts exactly one cycle:
  - finished_transaction=1; step=0, travel=0, busy=0.
  - done_count increments on entry, saturating at 2^CNT_W-1.
  - Next state is IDLE unconditionally; start_transaction in DONE is ignored.
- FAIL lasts exactly one cycle:
  - failed_transaction=1.
  - fail_code=idx, latched on the entry edge.
  - Next state is IDLE unconditionally.
- Watchdog, only when TIMEOUT_CYCLES>0:
  - Counter clears on every state entry and increments each cycle spent in TRAVEL or STEP.
  - Expiry = counter==TIMEOUT_CYCLES-1 with no advancing event that cycle.
  - Net effect: a phase occupies at most TIMEOUT_CYCLES cycles.
- Inputs done_travel, done_step, step_fail and abort are ignored in IDLE, DONE and FAIL.
- Minimum transaction latency: 2*NUM_STEPS+1 cycles from the start edge to the finished_transaction pulse, when every done is asserted immediately.
- finished_transaction and failed_transaction are never high in the same cycle.
- Outputs are glitch-free decodes of registered state. No latches: every combinational output has a default assignment.

Test Plan:
- Happy path (NUM_STEPS=4, done_travel and done_step held high, start pulse at cycle 0):
  - step sequence is 1,1,2,2,3,3,4,4, then 0.
  - travel sequence is 1,0,2,0,3,0,4,0.
  - finished_transaction=1 at cycle 9; done_count=1.
- Step failure: step_fail=1 during STEP idx=2 → failed_transaction pulse, fail_code=2, timeout=0, done_count unchanged, IDLE next cycle.
- Watchdog (TIMEOUT_CYCLES=8): hold done_travel=0 in TRAVEL idx=3 → failed_transaction exactly 8 cycles after TRAVEL entry, fail_code=3, timeout=1.
- Priority check:
  - abort and done_step together at idx=1 → FAIL, fail_code=1.
  - done_step and watchdog expiry together → advances to TRAVEL idx=2, no fail.
- Reset and start gating:
  - resetn=0 during STEP idx=3 → all outputs 0 next cycle, no pulse.
  - start_transaction during busy → ignored; start in IDLE after FAIL clears fail_code to 0.
- Saturation (CNT_W=2): 5 back-to-back successful transactions → done_count reads 1,2,3,3,3.

Source files
------------

// File: rtl/transaction_sequencer.sv
// Sequences NUM_STEPS travel/step phase pairs per transaction and reports success or failure,
// with abort, step-failure, per-phase watchdog and a saturating success counter.
module transaction_sequencer #(
    parameter int unsigned NUM_STEPS      = 4,
    parameter int unsigned IDX_W          = 3,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 8
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             start_transaction,
    input  logic             done_travel,
    input  logic             done_step,
    input  logic             step_fail,
    input  logic             abort,
    output logic [IDX_W-1:0] step,
    output logic [IDX_W-1:0] travel,
    output logic             busy,
    output logic             finished_transaction,
    output logic             failed_transaction,
    output logic [IDX_W-1:0] fail_code,
    output logic             timeout,
    output logic [CNT_W-1:0] done_count
);

    localparam int unsigned WdW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned WdLastInt = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam bit          WdEn      = (TIMEOUT_CYCLES > 0);

    localparam logic [WdW-1:0]   WdLast   = WdW'(WdLastInt);
    localparam logic [IDX_W-1:0] FirstIdx = IDX_W'(1);
    localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(NUM_STEPS);
    localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};

    typedef enum logic [2:0] {StIdle, StTravel, StStep, StDone, StFail} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WdW-1:0]   wd_q, wd_d;
    logic [IDX_W-1:0] fail_code_q, fail_code_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] done_count_q, done_count_d;

    logic             wd_expired;
    logic [WdW-1:0]   wd_inc;

    // Expiry only fires when no advancing event is seen; the caller checks events first.
    assign wd_expired = WdEn && (wd_q == WdLast);
    assign wd_inc     = WdEn ? wd_q + WdW'(1) : '0;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            wd_q         <= '0;
            fail_code_q  <= '0;
            timeout_q    <= 1'b0;
            done_count_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wd_q         <= wd_d;
            fail_code_q  <= fail_code_d;
            timeout_q    <= timeout_d;
            done_count_q <= done_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        wd_d         = '0;
        fail_code_d  = fail_code_q;
        timeout_d    = timeout_q;
        done_count_d = done_count_q;
        unique case (state_q)
            StIdle: begin
                if (start_transaction) begin
                    state_d     = StTravel;
                    idx_d       = FirstIdx;
                    fail_code_d = '0;
                    timeout_d   = 1'b0;
                end
            end
            StTravel: begin
                if (abort) begin
                    state_d     = StFail;
                    fail_code_d = idx_q;
                end else if (done_travel) begin
                    state_d = StStep;
                end else if (wd_expired) begin
                    state_d     = StFail;
                    fail_code_d = idx_q;
                    timeout_d   = 1'b1;
                end else begin
                    wd_d = wd_inc;
                end
            end
            StStep: begin
                if (abort || step_fail) begin
                    state_d     = StFail;
                    fail_code_d = idx_q;
                end else if (done_step) begin
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                        if (done_count_q != CntMax) begin
                            done_count_d = done_count_q + CNT_W'(1);
                        end
                    end else begin
                        state_d = StTravel;
                        idx_d   = idx_q + FirstIdx;
                    end
                end else if (wd_expired) begin
                    state_d     = StFail;
                    fail_code_d = idx_q;
                    timeout_d   = 1'b1;
                end else begin
                    wd_d = wd_inc;
                end
            end
            StDone, StFail: begin
                state_d = StIdle;
                idx_d   = '0;
            end
            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    always_comb begin
        step                 = '0;
        travel               = '0;
        busy                 = 1'b0;
        finished_transaction = 1'b0;
        failed_transaction   = 1'b0;
        unique case (state_q)
            StTravel: begin
                busy   = 1'b1;
                step   = idx_q;
                travel = idx_q;
            end
            StStep: begin
                busy = 1'b1;
                step = idx_q;
            end
            StDone:  finished_transaction = 1'b1;
            StFail:  failed_transaction   = 1'b1;
            default: ;
        endcase
    end

    assign fail_code  = fail_code_q;
    assign timeout    = timeout_q;
    assign done_count = done_count_q;

endmodule

// File: tb/tb_transaction_sequencer.sv
// Self-checking bench: directed scenarios plus randomized transactions checked against a
// phase-level reference model (per-phase delays, outcome and cycle-by-cycle index trace).
module tb_transaction_sequencer;

    localparam int unsigned NS = 4;
    localparam int unsigned IW = 3;
    localparam int unsigned TO = 8;
    localparam int unsigned CW = 2;

    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic start_transaction = 1'b0;
    logic done_travel = 1'b0;
    logic done_step = 1'b0;
    logic step_fail = 1'b0;
    logic abort = 1'b0;

    logic [IW-1:0] step, travel, fail_code;
    logic          busy, finished_transaction, failed_transaction, timeout;
    logic [CW-1:0] done_count;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;

    transaction_sequencer #(
        .NUM_STEPS(NS), .IDX_W(IW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
    ) dut (
        .clock(clock), .resetn(resetn), .start_transaction(start_transaction),
        .done_travel(done_travel), .done_step(done_step), .step_fail(step_fail),
        .abort(abort), .step(step), .travel(travel), .busy(busy),
        .finished_transaction(finished_transaction), .failed_transaction(failed_transaction),
        .fail_code(fail_code), .timeout(timeout), .done_count(done_count)
    );

    always #5 clock = ~clock;

    function automatic int sat_inc(input int v);
        return (v < (1 << CW) - 1) ? v + 1 : v;
    endfunction

    task automatic clear_inputs();
        start_transaction = 1'b0;
        done_travel = 1'b0;
        done_step = 1'b0;
        step_fail = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clear_inputs();
        @(negedge clock);
        @(negedge clock);
        checks++;
        if ({step, travel, busy, finished_transaction, failed_transaction, fail_code, timeout,
             done_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got step=%0d travel=%0d busy=%b fail_code=%0d cnt=%0d want all 0",
                     step, travel, busy, fail_code, done_count);
        end
        resetn = 1'b1;
        exp_count = 0;
        @(negedge clock);
        checks++;
        if ({step, busy, finished_transaction, failed_transaction, done_count} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got step=%0d busy=%b fin=%b fail=%b want 0",
                     step, busy, finished_transaction, failed_transaction);
        end
    endtask

    task automatic test_happy_path();
        int k;
        int et;
        start_transaction = 1'b1; done_travel = 1'b1; done_step = 1'b1;
        @(negedge clock);
        start_transaction = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            k = (c + 1) / 2;
            et = (c % 2 == 1) ? k : 0;
            checks++;
            if (step !== IW'(k) || travel !== IW'(et) || busy !== 1'b1 ||
                finished_transaction !== 1'b0) begin
                errors++;
                $display("FAIL happy_cycle%0d: got step=%0d travel=%0d busy=%b want step=%0d travel=%0d busy=1",
                         c, step, travel, busy, k, et);
            end
            @(negedge clock);
        end
        exp_count = sat_inc(exp_count);
        checks++;
        if (finished_transaction !== 1'b1 || {step, travel, busy} !== '0 ||
            done_count !== CW'(exp_count)) begin
            errors++;
            $display("FAIL happy_done: got fin=%b step=%0d busy=%b cnt=%0d want fin=1 step=0 busy=0 cnt=%0d",
                     finished_transaction, step, busy, done_count, exp_count);
        end
        clear_inputs();
        @(negedge clock);
        checks++;
        if (finished_transaction !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL happy_idle: got fin=%b busy=%b want 0 0", finished_transaction, busy);
        end
    endtask

    task automatic test_step_fail();
        start_transaction = 1'b1; done_travel = 1'b1; done_step = 1'b1;
        @(negedge clock);
        start_transaction = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (step !== IW'(2) || travel !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL stepfail_pos: got step=%0d travel=%0d want step=2 travel=0", step, travel);
        end
        step_fail = 1'b1;
        @(negedge clock);
        checks++;
        if (failed_transaction !== 1'b1 || finished_transaction !== 1'b0 || fail_code !== IW'(2) ||
            timeout !== 1'b0 || done_count !== CW'(exp_count) || busy !== 1'b0) begin
            errors++;
            $display("FAIL stepfail_pulse: got fail=%b fin=%b code=%0d tmo=%b cnt=%0d want 1 0 2 0 %0d",
                     failed_transaction, finished_transaction, fail_code, timeout, done_count, exp_count);
        end
        clear_inputs();
        @(negedge clock);
        checks++;
        if (failed_transaction !== 1'b0 || busy !== 1'b0 || fail_code !== IW'(2)) begin
            errors++;
            $display("FAIL stepfail_idle: got fail=%b busy=%b code=%0d want 0 0 2",
                     failed_transaction, busy, fail_code);
        end
    endtask

    task automatic test_watchdog();
        start_transaction = 1'b1; done_travel = 1'b1; done_step = 1'b1;
        @(negedge clock);
        start_transaction = 1'b0;
        repeat (4) @(negedge clock);
        done_travel = 1'b0; done_step = 1'b0;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (travel !== IW'(3) || busy !== 1'b1 || failed_transaction !== 1'b0) begin
                errors++;
                $display("FAIL wdog_wait%0d: got travel=%0d busy=%b fail=%b want 3 1 0",
                         c, travel, busy, failed_transaction);
            end
            @(negedge clock);
        end
        checks++;
        if (failed_transaction !== 1'b1 || fail_code !== IW'(3) || timeout !== 1'b1) begin
            errors++;
            $display("FAIL wdog_expire: got fail=%b code=%0d tmo=%b want 1 3 1",
                     failed_transaction, fail_code, timeout);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || failed_transaction !== 1'b0 || timeout !== 1'b1 ||
            fail_code !== IW'(3)) begin
            errors++;
            $display("FAIL wdog_hold: got busy=%b fail=%b tmo=%b code=%0d want 0 0 1 3",
                     busy, failed_transaction, timeout, fail_code);
        end
    endtask

    task automatic test_start_gating();
        start_transaction = 1'b1; done_travel = 1'b1; done_step = 1'b1;
        @(negedge clock);
        checks++;
        if (fail_code !== '0 || timeout !== 1'b0 || step !== IW'(1) || travel !== IW'(1)) begin
            errors++;
            $display("FAIL gate_clear: got code=%0d tmo=%b step=%0d travel=%0d want 0 0 1 1",
                     fail_code, timeout, step, travel);
        end
        repeat (7) @(negedge clock);
        checks++;
        if (step !== IW'(4) || travel !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL gate_busy_ignored: got step=%0d travel=%0d want 4 0", step, travel);
        end
        @(negedge clock);
        exp_count = sat_inc(exp_count);
        checks++;
        if (finished_transaction !== 1'b1 || done_count !== CW'(exp_count)) begin
            errors++;
            $display("FAIL gate_done: got fin=%b cnt=%0d want 1 %0d",
                     finished_transaction, done_count, exp_count);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || finished_transaction !== 1'b0) begin
            errors++;
            $display("FAIL gate_done_ignores_start: got busy=%b fin=%b want 0 0",
                     busy, finished_transaction);
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b1 || step !== IW'(1) || travel !== IW'(1)) begin
            errors++;
            $display("FAIL gate_idle_start: got busy=%b step=%0d travel=%0d want 1 1 1",
                     busy, step, travel);
        end
        start_transaction = 1'b0;
        abort = 1'b1;
        @(negedge clock);
        checks++;
        if (failed_transaction !== 1'b1 || fail_code !== IW'(1) || timeout !== 1'b0) begin
            errors++;
            $display("FAIL gate_abort_travel: got fail=%b code=%0d tmo=%b want 1 1 0",
                     failed_transaction, fail_code, timeout);
        end
        clear_inputs();
        @(negedge clock);
    endtask

    task automatic test_priority();
        start_transaction = 1'b1; done_travel = 1'b1;
        @(negedge clock);
        start_transaction = 1'b0;
        @(negedge clock);
        abort = 1'b1; done_step = 1'b1;
        @(negedge clock);
        checks++;
        if (failed_transaction !== 1'b1 || finished_transaction !== 1'b0 || fail_code !== IW'(1) ||
            busy !== 1'b0) begin
            errors++;
            $display("FAIL prio_abort_done: got fail=%b fin=%b code=%0d busy=%b want 1 0 1 0",
                     failed_transaction, finished_transaction, fail_code, busy);
        end
        clear_inputs();
        @(negedge clock);
        start_transaction = 1'b1; done_travel = 1'b1;
        @(negedge clock);
        start_transaction = 1'b0;
        @(negedge clock);
        done_travel = 1'b0;
        for (int c = 0; c < 7; c++) begin
            checks++;
            if (step !== IW'(1) || travel !== '0 || failed_transaction !== 1'b0) begin
                errors++;
                $display("FAIL prio_wait%0d: got step=%0d travel=%0d fail=%b want 1 0 0",
                         c, step, travel, failed_transaction);
            end
            @(negedge clock);
        end
        done_step = 1'b1;
        @(negedge clock);
        checks++;
        if (travel !== IW'(2) || failed_transaction !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL prio_done_vs_wdog: got travel=%0d fail=%b busy=%b want 2 0 1",
                     travel, failed_transaction, busy);
        end
        done_step = 1'b0; abort = 1'b1;
        @(negedge clock);
        checks++;
        if (failed_transaction !== 1'b1 || fail_code !== IW'(2) || timeout !== 1'b0) begin
            errors++;
            $display("FAIL prio_abort_travel2: got fail=%b code=%0d tmo=%b want 1 2 0",
                     failed_transaction, fail_code, timeout);
        end
        clear_inputs();
        @(negedge clock);
    endtask

    task automatic test_random(input int ntx);
        int q_step[$];
        int q_trav[$];
        bit q_dt[$], q_ds[$], q_sf[$], q_ab[$], q_st[$];
        bit ok, tmo, stop, is_trav, act;
        int fcode, k, r, d, kind, len;
        logic [3*IW+3:0] got, want;
        logic [2*IW+CW+3:0] got_e, want_e;
        for (int n = 0; n < ntx; n++) begin
            q_step.delete(); q_trav.delete(); q_dt.delete(); q_ds.delete();
            q_sf.delete(); q_ab.delete(); q_st.delete();
            ok = 1'b1; tmo = 1'b0; stop = 1'b0; fcode = 0;
            // Each phase: done after d idle cycles, or the watchdog if d >= TO.
            for (int j = 0; j < 2 * NS && !stop; j++) begin
                k = j / 2 + 1;
                is_trav = (j % 2 == 0);
                r = int'($urandom_range(0, 19));
                d = (r == 0) ? TO + 2 : (r == 1) ? TO - 1 : int'($urandom_range(0, 3));
                kind = int'($urandom_range(0, 11));
                if (is_trav && kind == 1) kind = 2;
                len = (d < TO) ? d + 1 : TO;
                for (int c = 0; c < len; c++) begin
                    act = (c == d);
                    q_step.push_back(k);
                    q_trav.push_back(is_trav ? k : 0);
                    q_st.push_back($urandom_range(0, 1) == 1);
                    q_ab.push_back(act && kind == 0);
                    if (is_trav) begin
                        q_dt.push_back(act && kind >= 2);
                        q_ds.push_back($urandom_range(0, 1) == 1);
                        q_sf.push_back($urandom_range(0, 1) == 1);
                    end else begin
                        q_dt.push_back($urandom_range(0, 1) == 1);
                        q_sf.push_back(act && kind == 1);
                        q_ds.push_back(act && (kind >= 2 || $urandom_range(0, 1) == 1));
                    end
                end
                if (d >= TO) begin
                    ok = 1'b0; fcode = k; tmo = 1'b1; stop = 1'b1;
                end else if (kind <= 1) begin
                    ok = 1'b0; fcode = k; stop = 1'b1;
                end
            end

            clear_inputs();
            start_transaction = 1'b1;
            @(negedge clock);
            for (int i = 0; i < q_step.size(); i++) begin
                got  = {step, travel, busy, finished_transaction, failed_transaction, fail_code, timeout};
                want = {IW'(q_step[i]), IW'(q_trav[i]), 3'b100, IW'(0), 1'b0};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL rand_busy txn=%0d cyc=%0d: got %b want %b", n, i, got, want);
                end
                start_transaction = q_st[i];
                done_travel = q_dt[i];
                done_step = q_ds[i];
                step_fail = q_sf[i];
                abort = q_ab[i];
                @(negedge clock);
            end
            if (ok) exp_count = sat_inc(exp_count);
            got_e  = {finished_transaction, failed_transaction, fail_code, timeout, done_count, busy, step};
            want_e = {ok, !ok, IW'(fcode), tmo, CW'(exp_count), 1'b0, IW'(0)};
            checks++;
            if (got_e !== want_e) begin
                errors++;
                $display("FAIL rand_end txn=%0d: got %b want %b", n, got_e, want_e);
            end
            clear_inputs();
            start_transaction = ($urandom_range(0, 1) == 1);
            done_travel = 1'b1; done_step = 1'b1; abort = 1'b1;
            @(negedge clock);
            checks++;
            if ({busy, finished_transaction, failed_transaction} !== 3'b000) begin
                errors++;
                $display("FAIL rand_idle txn=%0d: got busy=%b fin=%b fail=%b want 0 0 0",
                         n, busy, finished_transaction, failed_transaction);
            end
            clear_inputs();
        end
    endtask

    task automatic test_reset_mid();
        start_transaction = 1'b1; done_travel = 1'b1; done_step = 1'b1;
        @(negedge clock);
        start_transaction = 1'b0;
        repeat (5) @(negedge clock);
        checks++;
        if (step !== IW'(3) || travel !== '0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pos: got step=%0d travel=%0d busy=%b want 3 0 1", step, travel, busy);
        end
        resetn = 1'b0;
        @(negedge clock);
        exp_count = 0;
        checks++;
        if ({step, travel, busy, finished_transaction, failed_transaction, fail_code, timeout,
             done_count} !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got step=%0d busy=%b fin=%b fail=%b cnt=%0d want all 0",
                     step, busy, finished_transaction, failed_transaction, done_count);
        end
        resetn = 1'b1;
        clear_inputs();
        @(negedge clock);
        checks++;
        if ({busy, finished_transaction, failed_transaction, done_count} !== '0) begin
            errors++;
            $display("FAIL rstmid_nopulse: got busy=%b fin=%b fail=%b cnt=%0d want 0",
                     busy, finished_transaction, failed_transaction, done_count);
        end
    endtask

    task automatic test_back_to_back();
        int exp_sat[5];
        exp_sat = '{1, 2, 3, 3, 3};
        start_transaction = 1'b1; done_travel = 1'b1; done_step = 1'b1;
        @(negedge clock);
        for (int t = 0; t < 5; t++) begin
            repeat (8) @(negedge clock);
            checks++;
            if (finished_transaction !== 1'b1 || done_count !== CW'(exp_sat[t])) begin
                errors++;
                $display("FAIL b2b_count%0d: got fin=%b cnt=%0d want 1 %0d",
                         t, finished_transaction, done_count, exp_sat[t]);
            end
            @(negedge clock);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_idle%0d: got busy=%b want 0", t, busy);
            end
            @(negedge clock);
        end
        clear_inputs();
        repeat (2) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_happy_path();
        test_step_fail();
        test_watchdog();
        test_start_gating();
        test_priority();
        test_random(60);
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got still running want finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
